// File: rtl/fir_channel_scheduler.sv
// Shares one FIR filter engine between CHANNELS sample streams, one sample in flight at a time.
// Define FIR_SCHED_FIXED_PRIORITY_EN for lowest-index-wins arbitration; default is round-robin.
module fir_channel_scheduler #(
  parameter int DATA_WIDTH     = 24,
  parameter int CHANNELS       = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CH_WIDTH      = $clog2(CHANNELS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_en,
  input  logic [CHANNELS*DATA_WIDTH-1:0] iv_ch_din,
  input  logic [CHANNELS-1:0]            iv_ch_din_valid,
  output logic [CHANNELS-1:0]            ov_ch_din_ready,
  output logic [DATA_WIDTH-1:0]          ov_flt_din,
  output logic                           o_flt_din_valid,
  input  logic                           i_flt_ready,
  output logic [CH_WIDTH-1:0]            ov_flt_chan,
  input  logic [DATA_WIDTH-1:0]          iv_flt_dout,
  input  logic                           i_flt_dout_valid,
  output logic                           o_flt_ready,
  output logic [DATA_WIDTH-1:0]          ov_dout,
  output logic [CH_WIDTH-1:0]            ov_dout_chan,
  output logic                           o_dout_valid,
  input  logic                           i_dout_ready,
  output logic                           o_busy,
  output logic                           o_timeout,
  output logic [2:0]                     ov_dbg_state
);

  localparam int TO_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  // Handshakes: a channel sample transfers on the cycle its ov_ch_din_ready bit pulses;
  // the filter takes ov_flt_din on an i_flt_ready pulse while o_flt_din_valid is high;
  // a filter result transfers when o_flt_ready pulses; downstream takes ov_dout on a
  // cycle where o_dout_valid and i_dout_ready are both high.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_ACK     = 3'd3,
    S_DELIVER = 3'd4
  } state_t;

  state_t               state;
  logic [TO_WIDTH-1:0]  to_cnt;
  logic [CH_WIDTH-1:0]  grant_idx;
  logic                 grant_hit;
  logic [CHANNELS-1:0]  grant_onehot;
  logic [DATA_WIDTH-1:0] grant_sample;

`ifdef FIR_SCHED_FIXED_PRIORITY_EN
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (iv_ch_din_valid[i]) begin
        grant_hit = 1'b1;
        grant_idx = CH_WIDTH'(i);
      end
    end
  end
`else
  logic [CH_WIDTH-1:0] last_grant;

  // Scan backwards so the requester closest after last_grant is the final writer.
  always_comb begin : rr_arb
    int k;
    k         = 0;
    grant_hit = 1'b0;
    grant_idx = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      k = (int'(last_grant) + i) % CHANNELS;
      if (iv_ch_din_valid[k]) begin
        grant_hit = 1'b1;
        grant_idx = CH_WIDTH'(k);
      end
    end
  end
`endif

  assign grant_onehot = {{(CHANNELS-1){1'b0}}, 1'b1} << grant_idx;
  assign grant_sample = iv_ch_din[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign ov_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      to_cnt          <= '0;
      ov_ch_din_ready <= '0;
      ov_flt_din      <= '0;
      o_flt_din_valid <= 1'b0;
      ov_flt_chan     <= '0;
      o_flt_ready     <= 1'b0;
      ov_dout         <= '0;
      ov_dout_chan    <= '0;
      o_dout_valid    <= 1'b0;
      o_busy          <= 1'b0;
      o_timeout       <= 1'b0;
`ifndef FIR_SCHED_FIXED_PRIORITY_EN
      last_grant      <= CH_WIDTH'(CHANNELS - 1);
`endif
    end else if (i_en) begin
      ov_ch_din_ready <= '0;
      o_flt_ready     <= 1'b0;
      case (state)
        S_IDLE: begin
          // A result arriving after a timeout abort is acknowledged once and dropped.
          o_flt_ready <= i_flt_dout_valid && !o_flt_ready;
          if (grant_hit) begin
            ov_ch_din_ready <= grant_onehot;
            ov_flt_din      <= grant_sample;
            ov_flt_chan     <= grant_idx;
            o_flt_din_valid <= 1'b1;
            to_cnt          <= '0;
            o_busy          <= 1'b1;
            state           <= S_ISSUE;
`ifndef FIR_SCHED_FIXED_PRIORITY_EN
            last_grant      <= grant_idx;
`endif
          end
        end
        S_ISSUE: begin
          if (to_cnt == TO_LAST) begin
            o_timeout       <= 1'b1;
            o_flt_din_valid <= 1'b0;
            o_busy          <= 1'b0;
            state           <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_WIDTH'(1);
            if (i_flt_ready) begin
              o_flt_din_valid <= 1'b0;
              state           <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (to_cnt == TO_LAST) begin
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            state     <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_WIDTH'(1);
            if (i_flt_dout_valid) begin
              ov_dout      <= iv_flt_dout;
              ov_dout_chan <= ov_flt_chan;
              o_flt_ready  <= 1'b1;
              state        <= S_ACK;
            end
          end
        end
        S_ACK: begin
          o_dout_valid <= 1'b1;
          state        <= S_DELIVER;
        end
        S_DELIVER: begin
          if (i_dout_ready) begin
            o_dout_valid <= 1'b0;
            o_busy       <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Bench for fir_channel_scheduler: behavioural filter/source/sink plus arbitration model and result scoreboard.
module tb_fir_channel_scheduler;

  localparam int DW = 24;
  localparam int CH = 4;
  localparam int CW = 2;
  localparam int TO = 32;
  localparam int EW = CW + DW;

  // clock / reset
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic              i_rst_n;
  logic              i_en;
  logic [CH*DW-1:0]  iv_ch_din;
  logic [CH-1:0]     iv_ch_din_valid;
  logic [CH-1:0]     ov_ch_din_ready;
  logic [DW-1:0]     ov_flt_din;
  logic              o_flt_din_valid;
  logic              i_flt_ready;
  logic [CW-1:0]     ov_flt_chan;
  logic [DW-1:0]     iv_flt_dout;
  logic              i_flt_dout_valid;
  logic              o_flt_ready;
  logic [DW-1:0]     ov_dout;
  logic [CW-1:0]     ov_dout_chan;
  logic              o_dout_valid;
  logic              i_dout_ready;
  logic              o_busy;
  logic              o_timeout;
  logic [2:0]        dbg_state;

  fir_channel_scheduler #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
    .iv_ch_din(iv_ch_din), .iv_ch_din_valid(iv_ch_din_valid), .ov_ch_din_ready(ov_ch_din_ready),
    .ov_flt_din(ov_flt_din), .o_flt_din_valid(o_flt_din_valid), .i_flt_ready(i_flt_ready),
    .ov_flt_chan(ov_flt_chan), .iv_flt_dout(iv_flt_dout), .i_flt_dout_valid(i_flt_dout_valid),
    .o_flt_ready(o_flt_ready), .ov_dout(ov_dout), .ov_dout_chan(ov_dout_chan),
    .o_dout_valid(o_dout_valid), .i_dout_ready(i_dout_ready), .o_busy(o_busy),
    .o_timeout(o_timeout), .ov_dbg_state(dbg_state)
  );

  // scoreboard and reference state
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] smp [CH];
  logic [CH-1:0] pend;
  int            model_last;
  logic          exp_to;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [CH-1:0] m);
`ifdef FIR_SCHED_FIXED_PRIORITY_EN
    for (int i = 0; i < CH; i++) if (m[i]) return i;
`else
    for (int s = 1; s <= CH; s++) if (m[(model_last + s) % CH]) return (model_last + s) % CH;
`endif
    return 0;
  endfunction

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic drive_valids();
    iv_ch_din_valid = pend;
    for (int k = 0; k < CH; k++) iv_ch_din[k*DW +: DW] = smp[k];
  endtask

  task automatic reset_checks();
    check("rst_ch_din_ready", ov_ch_din_ready, 0);
    check("rst_flt_din", ov_flt_din, 0);
    check("rst_flt_din_valid", o_flt_din_valid, 0);
    check("rst_flt_chan", ov_flt_chan, 0);
    check("rst_flt_ready", o_flt_ready, 0);
    check("rst_dout", ov_dout, 0);
    check("rst_dout_chan", ov_dout_chan, 0);
    check("rst_dout_valid", o_dout_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_dbg_state", dbg_state, 0);
  endtask

  // driver: wait for the grant, check the issue outputs, then apply an optional enable freeze
  task automatic issue_phase(input int en_off, input bit refill, output int g);
    int exp_g;
    int w;
    exp_g = pick(pend);
    for (w = 0; w < 8; w++) begin
      step();
      if (ov_ch_din_ready != 0) break;
    end
    check("grant_lat", w, 0);
    check("ch_din_ready", ov_ch_din_ready, 64'd1 << exp_g);
    check("flt_chan", ov_flt_chan, exp_g);
    check("flt_din_valid", o_flt_din_valid, 1);
    check("flt_din", ov_flt_din, smp[exp_g]);
    check("busy_issue", o_busy, 1);
    g = exp_g;
    model_last = exp_g;
    if (refill) begin
      smp[g] = DW'($urandom);
      pend[g] = 1'b1;
    end else begin
      pend[g] = 1'b0;
    end
    drive_valids();
    if (en_off > 0) begin
      i_en = 1'b0;
      repeat (en_off) step();
      check("en_hold_ch_ready", ov_ch_din_ready, 64'd1 << exp_g);
      check("en_hold_din_valid", o_flt_din_valid, 1);
      check("en_hold_busy", o_busy, 1);
      i_en = 1'b1;
    end
  endtask

  task automatic flt_accept(input int d, input bit with_result);
    repeat (d) step();
    i_flt_ready = 1'b1;
    if (with_result) i_flt_dout_valid = 1'b1;
    step();
    i_flt_ready = 1'b0;
    check("din_valid_drop", o_flt_din_valid, 0);
    check("ch_ready_pulse", ov_ch_din_ready, 0);
  endtask

  task automatic txn(input int en_off, input int d, input int lat, input int hold,
                     input bit refill, input logic [DW-1:0] res);
    int g;
    int w;
    logic [EW-1:0] e;
    issue_phase(en_off, refill, g);
    iv_flt_dout = res;
    exp_q.push_back({CW'(g), res});
    if (lat == 0) begin
      flt_accept(d, 1'b1);
    end else begin
      flt_accept(d, 1'b0);
      repeat (lat - 1) step();
      i_flt_dout_valid = 1'b1;
    end
    for (w = 1; w <= 8; w++) begin
      step();
      if (o_flt_ready) break;
    end
    check("flt_ack_lat", w, 1);
    i_flt_dout_valid = 1'b0;
    check("dout_valid_ack", o_dout_valid, 0);
    step();
    check("dout_valid", o_dout_valid, 1);
    check("flt_ready_pulse", o_flt_ready, 0);
    e = exp_q.pop_front();
    check("dout", ov_dout, e[DW-1:0]);
    check("dout_chan", ov_dout_chan, e[EW-1:DW]);
    check("timeout_flag", o_timeout, exp_to);
    repeat (hold) begin
      step();
      check("hold_valid", o_dout_valid, 1);
      check("hold_dout", ov_dout, e[DW-1:0]);
      check("hold_chan", ov_dout_chan, e[EW-1:DW]);
      check("hold_no_grant", ov_ch_din_ready, 0);
    end
    i_dout_ready = 1'b1;
    step();
    i_dout_ready = 1'b0;
    check("dout_accept", o_dout_valid, 0);
    check("busy_idle", o_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int w;
    i_rst_n = 1'b0; i_en = 1'b1; i_flt_ready = 1'b0; i_flt_dout_valid = 1'b0;
    iv_flt_dout = '0; i_dout_ready = 1'b0; iv_ch_din = '0;
    for (int k = 0; k < CH; k++) smp[k] = '0;
    model_last = CH - 1; exp_to = 1'b0;

    // reset with ch1 requesting, filter answers 0x000456 after 20 cycles
    pend = 4'b0010; smp[1] = 24'h000123; drive_valids();
    repeat (3) step();
    reset_checks();
    i_rst_n = 1'b1;
    txn(0, 2, 20, 3, 1'b0, 24'h000456);

    // all channels requesting continuously
    for (int k = 0; k < CH; k++) smp[k] = DW'($urandom);
    pend = '1; drive_valids();
    repeat (8) txn(0, $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 2), 1'b1, DW'($urandom));

    // long downstream backpressure with other requesters waiting
    txn(0, 1, 3, 50, 1'b1, DW'($urandom));

    // enable low for 20 cycles in ISSUE: wall time exceeds the timeout, counted time does not
    txn(20, 2, 15, 2, 1'b0, DW'($urandom));
    pend = '0; drive_valids();

    // timeout: filter never takes the sample
    smp[2] = DW'($urandom); pend[2] = 1'b1; drive_valids();
    issue_phase(0, 1'b0, g);
    for (w = 1; w <= TO + 8; w++) begin
      step();
      if (o_timeout) break;
    end
    check("timeout_lat", w, TO);
    exp_to = 1'b1;
    check("to_busy", o_busy, 0);
    check("to_din_valid", o_flt_din_valid, 0);
    check("to_dout_valid", o_dout_valid, 0);
    // late result while idle
    iv_flt_dout = DW'($urandom); i_flt_dout_valid = 1'b1;
    step();
    check("late_ack", o_flt_ready, 1);
    i_flt_dout_valid = 1'b0;
    step();
    check("late_ack_pulse", o_flt_ready, 0);
    check("late_no_dout", o_dout_valid, 0);
    check("late_busy", o_busy, 0);
    for (int k = 0; k < CH; k++) smp[k] = DW'($urandom);
    pend = '1; drive_valids();
    txn(0, 1, 4, 1, 1'b0, DW'($urandom));

    // randomized traffic
    repeat (30) begin
      for (int k = 0; k < CH; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k] = 1'b1; smp[k] = DW'($urandom);
        end else if (pend[k] && $urandom_range(0, 7) == 0) begin
          pend[k] = 1'b0;
        end
      end
      if (pend == 0) pend[$urandom_range(0, CH - 1)] = 1'b1;
      drive_valids();
      txn(($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0, $urandom_range(0, 4),
          $urandom_range(0, 12), $urandom_range(0, 4), 1'($urandom_range(0, 1)), DW'($urandom));
    end
    pend = '0; drive_valids();

    // reset during WAIT_RESULT, then a ch2 sample completes
    smp[3] = DW'($urandom); pend[3] = 1'b1; drive_valids();
    issue_phase(0, 1'b0, g);
    flt_accept(1, 1'b0);
    repeat (3) step();
    #1 i_rst_n = 1'b0;
    #1 reset_checks();
    model_last = CH - 1; exp_to = 1'b0; exp_q.delete(); pend = '0; drive_valids();
    step(); step();
    i_rst_n = 1'b1;
    smp[2] = DW'($urandom); pend[2] = 1'b1; drive_valids();
    txn(0, 0, 5, 1, 1'b0, DW'($urandom));

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
